// File: rtl/cpu_local_bus_pkg.sv
// Purpose: shared state encoding, wait-code constant and width helpers for the local-bus decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_local_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } lb_state_t;

    // Wait code meaning "hold until the slave drives its own ack".
    localparam logic [3:0] WAIT_EXTACK = 4'hF;

    // Select index wide enough for NSLV windows plus the EXT code (value NSLV).
    function automatic int sel_width(input int nslv);
        return $clog2(nslv + 1);
    endfunction

    // Timeout counter width; at least one bit even when the timeout is disabled.
    function automatic int tcnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/cpu_local_bus_if.sv
// Purpose: bundles the CPU-side, local-slave and external-bus signals of the decoder.
// Latency: n/a (wiring only).
// Backpressure: cpu_stb is held by the master until cpu_ack or cpu_err.
interface cpu_local_bus_if #(
    parameter int NSLV = 4,
    parameter int AW   = 16,
    parameter int DW   = 16
);
    logic [AW-1:0]      cpu_adr;
    logic               cpu_stb;
    logic               cpu_we;
    logic               cpu_ack;
    logic               cpu_err;
    logic [DW-1:0]      cpu_dat;
    logic [NSLV-1:0]    slv_en;
    logic [NSLV*AW-1:0] slv_base;
    logic [NSLV*AW-1:0] slv_mask;
    logic [NSLV*4-1:0]  slv_wait;
    logic [NSLV-1:0]    slv_stb;
    logic [NSLV-1:0]    slv_ack;
    logic [NSLV*DW-1:0] slv_dat;
    logic               ext_stb;
    logic               ext_ack;
    logic [DW-1:0]      ext_dat;

    // Environment view: CPU, window configuration, slaves and external bus.
    modport master (
        output cpu_adr, cpu_stb, cpu_we, slv_en, slv_base, slv_mask, slv_wait,
               slv_ack, slv_dat, ext_ack, ext_dat,
        input  cpu_ack, cpu_err, cpu_dat, slv_stb, ext_stb
    );

    // Decoder view.
    modport slave (
        input  cpu_adr, cpu_stb, cpu_we, slv_en, slv_base, slv_mask, slv_wait,
               slv_ack, slv_dat, ext_ack, ext_dat,
        output cpu_ack, cpu_err, cpu_dat, slv_stb, ext_stb
    );
endinterface

// File: rtl/cpu_local_bus_match.sv
// Purpose: one address-window comparator; hit when enabled and all masked bits equal the base.
// Latency: combinational.
// Backpressure: none.
module lb_window_match
    import cpu_local_bus_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          i_en,
    input  logic [AW-1:0] i_adr,
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_mask,
    output logic          o_hit
);
    logic [AW-1:0] w_diff;

    assign w_diff = (i_adr ^ i_base) & i_mask;
    assign o_hit  = i_en & (w_diff == '0);
endmodule

// File: rtl/cpu_local_bus.sv
// Purpose: decodes CPU address into NSLV local windows or the external bus, generates ack/timeout.
// Latency: local ack after the window's wait count (0 = next cycle); slave/ext ack one cycle after sampling.
// Backpressure: one cycle in flight; new access accepted only from IDLE, ack/err held while cpu_stb is high.
module cpu_local_bus
    import cpu_local_bus_pkg::*;
#(
    parameter int NSLV    = 4,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_p,
    input  logic             dclo,
    cpu_local_bus_if.slave   bus
);
    localparam int             SW      = sel_width(NSLV);
    localparam int             TW      = tcnt_width(TIMEOUT);
    localparam logic [SW-1:0]  SEL_EXT = SW'(NSLV);
    localparam logic [TW-1:0]  T_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0]  T_MAX   = '1;

    lb_state_t     r_state;
    logic [SW-1:0] r_sel;
    logic [3:0]    r_wcnt;
    logic [TW-1:0] r_tcnt;

    logic [NSLV-1:0] w_hit;
    logic [SW-1:0]   w_sel;
    logic [3:0]      w_wait_new;
    logic            w_sel_ack;
    logic [DW-1:0]   w_sel_dat;
    logic            w_local;
    logic            w_active;
    logic            w_ack_now;
    logic            w_tmo;

    for (genvar g = 0; g < NSLV; g++) begin : g_win
        lb_window_match #(.AW(AW)) u_match (
            .i_en   (bus.slv_en[g]),
            .i_adr  (bus.cpu_adr),
            .i_base (bus.slv_base[g*AW +: AW]),
            .i_mask (bus.slv_mask[g*AW +: AW]),
            .o_hit  (w_hit[g])
        );
        assign bus.slv_stb[g] = bus.cpu_stb & w_active & (r_sel == SW'(g));
    end

    // Lowest-index hit wins; no hit selects the external bus. Also fetch that window's wait code.
    always_comb begin
        w_sel      = SEL_EXT;
        w_wait_new = 4'd0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel      = SW'(i);
                w_wait_new = bus.slv_wait[i*4 +: 4];
            end
        end
    end

    // Route the latched target's ack and read data.
    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_sel == SW'(i)) begin
                w_sel_ack = bus.slv_ack[i];
                w_sel_dat = bus.slv_dat[i*DW +: DW];
            end
        end
    end

    assign w_local   = (r_sel != SEL_EXT);
    assign w_active  = (r_state == S_WAIT) || (r_state == S_DONE);
    assign w_tmo     = (TIMEOUT != 0) && (r_tcnt == T_LAST);
    assign w_ack_now = w_local ? ((r_wcnt == WAIT_EXTACK) ? w_sel_ack : (r_wcnt <= 4'd1))
                               : bus.ext_ack;

    // Access sequencer: latch target, count wait states / timeout, hold ack or err until strobe drops.
    always_ff @(posedge clk_p or posedge dclo) begin
        if (dclo) begin
            r_state <= S_IDLE;
            r_sel   <= SEL_EXT;
            r_wcnt  <= 4'd0;
            r_tcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_stb) begin
                        r_sel  <= w_sel;
                        r_tcnt <= '0;
                        r_wcnt <= (w_sel != SEL_EXT) ? w_wait_new : 4'd0;
                        // Zero-wait local window acks in the very next cycle.
                        r_state <= ((w_sel != SEL_EXT) && (w_wait_new == 4'd0)) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.cpu_stb) begin
                        r_state <= S_IDLE;
                    end else if (w_ack_now) begin
                        r_state <= S_DONE;
                    end else if (w_tmo) begin
                        r_state <= S_ERR;
                    end else begin
                        if (w_local && (r_wcnt != WAIT_EXTACK) && (r_wcnt != 4'd0))
                            r_wcnt <= r_wcnt - 4'd1;
                        if (r_tcnt != T_MAX)
                            r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    if (!bus.cpu_stb)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_ack = bus.cpu_stb & (r_state == S_DONE);
    assign bus.cpu_err = bus.cpu_stb & (r_state == S_ERR);
    assign bus.ext_stb = bus.cpu_stb & w_active & ~w_local;
    assign bus.cpu_dat = ((r_state != S_IDLE) && w_local) ? w_sel_dat : bus.ext_dat;

endmodule

// File: tb/tb_cpu_local_bus.sv
// Purpose: directed bench for the local-bus decoder: decode, priority, wait/ack timing, timeout, abort, reset.
// Latency: cycles are counted from c0 = first cycle after the edge that samples cpu_stb in IDLE.
// Backpressure: bench holds cpu_stb until it has observed ack/err or chooses to abort.
module tb_cpu_local_bus;
    import cpu_local_bus_pkg::*;

    localparam int NSLV = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TIMEOUT = 64;

    logic clk_p = 1'b0;
    logic dclo  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cpu_local_bus_if #(.NSLV(NSLV), .AW(AW), .DW(DW)) bus ();

    cpu_local_bus #(.NSLV(NSLV), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_p (clk_p),
        .dclo  (dclo),
        .bus   (bus)
    );

    always #5 clk_p = ~clk_p;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_adr  = '0;
        bus.cpu_stb  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.slv_en   = 4'b0000;
        bus.slv_base = {16'o010000, 16'o170000, 16'o173000, 16'o160000};
        bus.slv_mask = {16'o170000, 16'o170000, 16'o177000, 16'o160000};
        bus.slv_wait = {4'hF, 4'd3, 4'd0, 4'd2};
        bus.slv_ack  = 4'b0000;
        bus.slv_dat  = {16'o033333, 16'o022222, 16'o011111, 16'o012345};
        bus.ext_ack  = 1'b0;
        bus.ext_dat  = 16'o177777;

        // Reset held with a live strobe: every output stays low.
        bus.slv_en  = 4'b0001;
        bus.cpu_adr = 16'o160010;
        bus.cpu_stb = 1'b1;
        tick(); tick();
        chk("rst_ack", 64'(bus.cpu_ack), 64'd0);
        chk("rst_err", 64'(bus.cpu_err), 64'd0);
        chk("rst_slv_stb", 64'(bus.slv_stb), 64'd0);
        chk("rst_ext_stb", 64'(bus.ext_stb), 64'd0);
        bus.cpu_stb = 1'b0;
        dclo = 1'b0;
        tick();

        // ROM-style window 0, wait 2.
        bus.cpu_adr = 16'o160010;
        bus.cpu_stb = 1'b1;
        tick();
        chk("rom_slv_stb_c0", 64'(bus.slv_stb), 64'b0001);
        chk("rom_ext_stb_c0", 64'(bus.ext_stb), 64'd0);
        chk("rom_ack_c0", 64'(bus.cpu_ack), 64'd0);
        tick();
        chk("rom_ack_c1", 64'(bus.cpu_ack), 64'd0);
        tick();
        chk("rom_ack_c2", 64'(bus.cpu_ack), 64'd1);
        chk("rom_slv_stb_c2", 64'(bus.slv_stb), 64'b0001);
        chk("rom_ext_stb_c2", 64'(bus.ext_stb), 64'd0);
        chk("rom_dat", 64'(bus.cpu_dat), 64'(16'o012345));
        bus.cpu_stb = 1'b0;
        #1;
        chk("rom_ack_drop", 64'(bus.cpu_ack), 64'd0);
        chk("rom_slv_stb_drop", 64'(bus.slv_stb), 64'd0);
        tick();

        // Overlapping windows 1 and 2; lower index wins, zero wait.
        bus.slv_en  = 4'b0110;
        bus.cpu_adr = 16'o173004;
        bus.cpu_stb = 1'b1;
        tick();
        chk("pri_slv_stb", 64'(bus.slv_stb), 64'b0010);
        chk("pri_ack_c0", 64'(bus.cpu_ack), 64'd1);
        chk("pri_dat", 64'(bus.cpu_dat), 64'(16'o011111));
        bus.cpu_stb = 1'b0;
        tick();

        // Miss to external bus; ext_ack raised in c5.
        bus.slv_en  = 4'b1111;
        bus.cpu_adr = 16'o001000;
        bus.cpu_stb = 1'b1;
        tick();
        chk("miss_ext_stb_c0", 64'(bus.ext_stb), 64'd1);
        chk("miss_slv_stb_c0", 64'(bus.slv_stb), 64'd0);
        chk("miss_ack_c0", 64'(bus.cpu_ack), 64'd0);
        repeat (4) tick();
        chk("miss_ack_c4", 64'(bus.cpu_ack), 64'd0);
        tick();
        bus.ext_ack = 1'b1;
        #1;
        chk("miss_ack_c5", 64'(bus.cpu_ack), 64'd0);
        tick();
        bus.ext_ack = 1'b0;
        chk("miss_ack_c6", 64'(bus.cpu_ack), 64'd1);
        chk("miss_dat", 64'(bus.cpu_dat), 64'(16'o177777));
        bus.cpu_stb = 1'b0;
        #1;
        chk("miss_ack_drop", 64'(bus.cpu_ack), 64'd0);
        tick();
        chk("miss_ext_stb_idle", 64'(bus.ext_stb), 64'd0);

        // Slave-driven ack on window 3: slv_ack in c7, cpu_ack in c8.
        bus.slv_en  = 4'b1000;
        bus.cpu_adr = 16'o010002;
        bus.cpu_stb = 1'b1;
        tick();
        chk("sack_slv_stb_c0", 64'(bus.slv_stb), 64'b1000);
        repeat (7) tick();
        bus.slv_ack = 4'b1000;
        #1;
        chk("sack_ack_c7", 64'(bus.cpu_ack), 64'd0);
        tick();
        bus.slv_ack = 4'b0000;
        chk("sack_ack_c8", 64'(bus.cpu_ack), 64'd1);
        chk("sack_dat", 64'(bus.cpu_dat), 64'(16'o033333));
        bus.cpu_stb = 1'b0;
        tick();

        // Slave ack in the same cycle the timeout would fire: ack wins.
        bus.cpu_stb = 1'b1;
        tick();
        repeat (TIMEOUT - 1) tick();
        bus.slv_ack = 4'b1000;
        #1;
        chk("race_ack_c63", 64'(bus.cpu_ack), 64'd0);
        chk("race_err_c63", 64'(bus.cpu_err), 64'd0);
        tick();
        bus.slv_ack = 4'b0000;
        chk("race_ack_c64", 64'(bus.cpu_ack), 64'd1);
        chk("race_err_c64", 64'(bus.cpu_err), 64'd0);
        bus.cpu_stb = 1'b0;
        tick();

        // External miss with no ack: error at c64.
        bus.cpu_adr = 16'o001000;
        bus.cpu_stb = 1'b1;
        tick();
        repeat (TIMEOUT - 1) tick();
        chk("tmo_err_c63", 64'(bus.cpu_err), 64'd0);
        chk("tmo_ext_stb_c63", 64'(bus.ext_stb), 64'd1);
        tick();
        chk("tmo_err_c64", 64'(bus.cpu_err), 64'd1);
        chk("tmo_ack_c64", 64'(bus.cpu_ack), 64'd0);
        chk("tmo_ext_stb_c64", 64'(bus.ext_stb), 64'd0);
        tick();
        chk("tmo_err_c65", 64'(bus.cpu_err), 64'd1);
        bus.cpu_stb = 1'b0;
        tick();
        chk("tmo_err_cleared", 64'(bus.cpu_err), 64'd0);

        // Reset asserted mid-WAIT.
        bus.slv_en  = 4'b0001;
        bus.cpu_adr = 16'o160010;
        bus.cpu_stb = 1'b1;
        tick();
        chk("mrst_slv_stb_c0", 64'(bus.slv_stb), 64'b0001);
        dclo = 1'b1;
        #1;
        chk("mrst_slv_stb", 64'(bus.slv_stb), 64'd0);
        chk("mrst_ack", 64'(bus.cpu_ack), 64'd0);
        chk("mrst_err", 64'(bus.cpu_err), 64'd0);
        chk("mrst_ext_stb", 64'(bus.ext_stb), 64'd0);
        bus.cpu_stb = 1'b0;
        tick();
        dclo = 1'b0;
        tick(); tick(); tick();
        chk("mrst_no_late_ack", 64'(bus.cpu_ack), 64'd0);

        // Early abort at wait count 1, then a clean external access.
        bus.cpu_stb = 1'b1;
        tick();
        tick();
        bus.cpu_stb = 1'b0;
        #1;
        chk("abort_slv_stb", 64'(bus.slv_stb), 64'd0);
        tick();
        chk("abort_ack", 64'(bus.cpu_ack), 64'd0);
        chk("abort_err", 64'(bus.cpu_err), 64'd0);
        bus.cpu_adr = 16'o001000;
        bus.cpu_stb = 1'b1;
        tick();
        chk("abort_next_ext_stb", 64'(bus.ext_stb), 64'd1);
        chk("abort_next_slv_stb", 64'(bus.slv_stb), 64'd0);
        chk("abort_next_ack", 64'(bus.cpu_ack), 64'd0);
        bus.cpu_stb = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_local_bus.md
Name: cpu_local_bus

Overview:
- Parametrised local-bus decoder and acknowledge generator that sits between a CPU core's Wishbone master port and its on-board local slaves (shadow ROMs, boot ROM, register block) and the shared external bus.
- Generalises the per-board hard-coded decode, fixed-delay ack and data mux into NSLV runtime-enabled address windows, each with a programmable wait count or slave-driven ack.
- Adds a bus-timeout error path, which the board modules do not currently have.

Parameters:
- NSLV, 4: number of local slave windows.
- AW, 16: address width.
- DW, 16: data width.
- TIMEOUT, 64: cycles without ack before a bus error is raised; 0 disables the timeout.

Ports:
- clk_p  in  1  system clock, all logic on rising edge.
- dclo  in  1  reset, asynchronous, active-high.
- cpu_adr  in  AW  CPU address.
- cpu_stb  in  1  CPU strobe; held until ack or err is seen.
- cpu_we  in  1  write enable (passed through only, not decoded).
- cpu_ack  out  1  acknowledge to CPU.
- cpu_err  out  1  bus timeout to CPU trap logic.
- cpu_dat  out  DW  read data to CPU.
- slv_en  in  NSLV  per-window enable, e.g. startup-register ROM bits.
- slv_base  in  NSLV*AW  window base; window i occupies bits [i*AW +: AW].
- slv_mask  in  NSLV*AW  compare mask; 1 means the bit is compared.
- slv_wait  in  NSLV*4  wait count per window; 4'hF means "wait for slv_ack".
- slv_stb  out  NSLV  one-hot slave strobe.
- slv_ack  in  NSLV  slave-driven ack, used only when the window's wait count is 4'hF.
- slv_dat  in  NSLV*DW  slave read data.
- ext_stb  out  1  strobe to the external/global bus.
- ext_ack  in  1  global ack.
- ext_dat  in  DW  global read data.

Behaviour:
- Reset: dclo async forces state IDLE, sel=EXT, counters 0. While reset is asserted, cpu_ack, cpu_err, slv_stb and ext_stb are all 0.
- Decode (combinational): hit[i] = slv_en[i] & ((cpu_adr ^ base_i) & mask_i) == 0. The lowest index wins; no hit selects EXT.
- FSM states: IDLE, WAIT, DONE, ERR.
- IDLE, with cpu_stb=1 at edge N:
  - latch sel; load wcnt = slv_wait[sel] (local targets only); clear tcnt; go to WAIT.
  - sel, slv_en, base and mask changes after edge N are ignored until the cycle ends.
- Strobe gating:
  - slv_stb[sel] = cpu_stb & (state==WAIT|DONE) & sel==i.
  - ext_stb = cpu_stb & (state==WAIT|DONE) & sel==EXT.
  - Both are first visible in cycle N+1.
- WAIT, local, wait count w != F:
  - wcnt decrements each cycle; when wcnt==0, go to DONE.
  - cpu_ack rises at cycle N+1+w. w=0 gives ack in N+1.
- WAIT, local, w == F: go to DONE on the cycle after slv_ack[sel]=1 is sampled.
- WAIT, EXT: go to DONE on the cycle after ext_ack=1 is sampled.
- DONE:
  - cpu_ack=1 as a registered level, held while cpu_stb=1.
  - cpu_stb=0 returns to IDLE. cpu_ack drops in that same cycle because it is gated by cpu_stb.
  - No back-to-back overlap: a new cycle is accepted only from IDLE.
- Timeout:
  - tcnt increments in WAIT. If TIMEOUT!=0 and tcnt==TIMEOUT-1 with no ack, go to ERR.
  - ERR: cpu_err=1 and cpu_ack=0, held until cpu_stb=0, then IDLE. slv_stb and ext_stb are 0 in ERR.
  - If the ack and the timeout land in the same cycle, the ack wins.
- Early abort: cpu_stb=0 while in WAIT returns to IDLE next edge, with no ack and no err. Strobes drop in the same cycle.
- Read data: cpu_dat = slv_dat[sel] when sel is local and state!=IDLE; otherwise ext_dat.
- Widths:
  - wcnt is 4 bits.
  - tcnt is max(1,$clog2(TIMEOUT+1)) bits and saturates, so it never wraps.
  - sel index is $clog2(NSLV+1) bits; the value NSLV encodes EXT.
- Mid-operation reset: aborts immediately, all outputs go low in the same cycle, and no spurious ack follows deassertion.

Decomposition:
- Package cpu_local_bus_pkg holds:
  - state encoding localparams (IDLE/WAIT/DONE/ERR);
  - WAIT_EXTACK = 4'hF;
  - the sel width function.
- One sub-module, lb_window_match: per-window compare, instantiated NSLV times, producing hit[i].
- Priority encode, FSM and muxes stay in the top.

Test Plan:
- ROM-style window: base 16'o160000, mask 16'o160000, en=1, wait=2. Read at 16'o160010 from edge N -> slv_stb[0] from N+1, cpu_ack at N+3, ext_stb never set, cpu_dat = slv_dat[0]=16'o012345.
- Priority overlap: window0 disabled, window1 = 16'o173000 (mask 16'o177000, wait=0), window2 = 16'o170000 (mask 16'o170000). Access to 16'o173004 -> slv_stb[1] only, ack at N+1.
- Miss: address 16'o001000, ext_ack asserted 5 cycles after ext_stb -> cpu_ack one cycle later, cpu_dat=ext_dat=16'o177777. Drop cpu_stb -> ack drops the same cycle, IDLE next.
- Slave ack: wait=F, slv_ack at cycle 7 -> ack at cycle 8. Separately, ack at cycle TIMEOUT-1 coinciding with timeout -> cpu_ack, not cpu_err.
- Timeout: TIMEOUT=64, miss, ext_ack never asserted -> cpu_err=1 at cycle 64, ext_stb=0 from then on, err clears when cpu_stb drops.
- Reset/abort: assert dclo during WAIT -> all outputs 0 immediately. Separately, drop cpu_stb at wait count 1 -> no ack, next access decodes normally.
